// File: rtl/vga_sync_decoder.sv
// VGA sync decoder: checks an incoming hsync/vsync pair against a fixed timing,
// locks after LOCK_FRAMES conforming frames, then recovers pixel coordinates.
module vga_sync_decoder #(
    parameter int H_VIS       = 640,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int V_VIS       = 480,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter int LOCK_FRAMES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hsync_in,
    input  logic       vsync_in,
    output logic [9:0] x_pos,
    output logic [9:0] y_pos,
    output logic       active,
    output logic       locked,
    output logic       frame_start,
    output logic       timing_err
);

    localparam logic [10:0] H_LAST    = 11'(H_VIS + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [10:0] V_LAST    = 11'(V_VIS + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [10:0] H_SYNC_W  = 11'(H_SYNC);
    localparam logic [10:0] V_SYNC_W  = 11'(V_SYNC);
    localparam logic [10:0] X_FIRST   = 11'(H_SYNC + H_BACK);
    localparam logic [10:0] X_LAST    = 11'(H_SYNC + H_BACK + H_VIS - 1);
    localparam logic [10:0] Y_FIRST   = 11'(V_SYNC + V_BACK);
    localparam logic [10:0] Y_LAST    = 11'(V_SYNC + V_BACK + V_VIS - 1);
    localparam logic [2:0]  LOCK_LAST = 3'(LOCK_FRAMES - 1);

    typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;

    state_t      state;
    logic        hs_s, vs_s, hs_p, vs_p;
    logic [10:0] h_cnt, v_cnt, vl_cnt;
    logic        v_pend;
    logic [2:0]  good;
    logic        bad, err;

    logic        h_fall, h_rise, v_fall, v_rise, viol, pend_next, in_win;
    logic [10:0] h_next, v_next, vl_next;

    // Input sample plus one-sample history for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_s <= 1'b1;
            vs_s <= 1'b1;
            hs_p <= 1'b1;
            vs_p <= 1'b1;
        end else begin
            hs_s <= hsync_in;
            vs_s <= vsync_in;
            hs_p <= hs_s;
            vs_p <= vs_s;
        end
    end

    always_comb begin
        h_fall    = hs_p & ~hs_s;
        h_rise    = ~hs_p & hs_s;
        v_fall    = vs_p & ~vs_s;
        v_rise    = ~vs_p & vs_s;
        h_next    = h_fall ? '0 : ((h_cnt == '1) ? h_cnt : h_cnt + 11'd1);
        v_next    = v_cnt;
        pend_next = v_pend;
        // A vsync fall waits for the next hsync fall (or the same sample) to zero v
        if (h_fall && (v_fall || v_pend)) begin
            v_next    = '0;
            pend_next = 1'b0;
        end else if (h_fall) begin
            v_next = (v_cnt == '1) ? v_cnt : v_cnt + 11'd1;
        end else if (v_fall) begin
            pend_next = 1'b1;
        end
        vl_next = vl_cnt;
        if (v_fall)
            vl_next = {10'd0, h_fall};
        else if (!vs_s && h_fall && vl_cnt != '1)
            vl_next = vl_cnt + 11'd1;
        // Frame length uses v_cnt before the reset to 0 on a coincident edge
        viol = (h_fall && h_cnt != H_LAST) ||
               (!h_fall && h_cnt == H_LAST) ||
               (h_rise && h_next != H_SYNC_W) ||
               (v_fall && v_cnt != V_LAST) ||
               (v_rise && vl_cnt != V_SYNC_W);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt  <= '0;
            v_cnt  <= '0;
            vl_cnt <= '0;
            v_pend <= 1'b0;
        end else begin
            h_cnt  <= h_next;
            v_cnt  <= v_next;
            vl_cnt <= vl_next;
            v_pend <= pend_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SEARCH;
            good  <= '0;
            bad   <= 1'b0;
            err   <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                SEARCH: begin
                    good <= '0;
                    bad  <= 1'b0;
                    if (v_fall) state <= CHECK;
                end
                CHECK: begin
                    if (viol) err <= 1'b1;
                    if (v_fall) begin
                        bad <= 1'b0;
                        if (viol || bad) begin
                            good <= '0;
                        end else begin
                            good <= good + 3'd1;
                            if (good == LOCK_LAST) state <= LOCKED;
                        end
                    end else if (viol) begin
                        bad  <= 1'b1;
                        good <= '0;
                    end
                end
                LOCKED: begin
                    if (viol) begin
                        err   <= 1'b1;
                        state <= SEARCH;
                    end
                end
                default: state <= SEARCH;
            endcase
        end
    end

    always_comb begin
        in_win = (state == LOCKED) &&
                 (h_cnt >= X_FIRST) && (h_cnt <= X_LAST) &&
                 (v_cnt >= Y_FIRST) && (v_cnt <= Y_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_pos       <= '0;
            y_pos       <= '0;
            active      <= 1'b0;
            locked      <= 1'b0;
            frame_start <= 1'b0;
            timing_err  <= 1'b0;
        end else begin
            x_pos       <= in_win ? 10'(h_cnt - X_FIRST) : '0;
            y_pos       <= in_win ? 10'(v_cnt - Y_FIRST) : '0;
            active      <= in_win;
            locked      <= (state == LOCKED);
            frame_start <= (state == LOCKED) && (h_cnt == '0) && (v_cnt == '0);
            timing_err  <= err;
        end
    end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder on a scaled-down 16x13 timing so whole
// frames fit in a short run; each sample carries its expected lock/error tags.
module tb_vga_sync_decoder;

    localparam int HV = 8, HF = 2, HS = 3, HB = 3;
    localparam int VV = 6, VF = 2, VS = 2, VB = 3;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       hsync_in = 1'b1;
    logic       vsync_in = 1'b1;
    logic [9:0] x_pos, y_pos;
    logic       active, locked, frame_start, timing_err;

    int   vectors = 0;
    int   miscompares = 0;
    int   t1_h = -1, t1_v = -1, t2_h = -1, t2_v = -1;
    logic t1_lk = 1'b0, t1_er = 1'b0, t2_lk = 1'b0, t2_er = 1'b0;

    vga_sync_decoder #(
        .H_VIS(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VIS(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .LOCK_FRAMES(2)
    ) dut (
        .clk(clk), .rst(rst), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .x_pos(x_pos), .y_pos(y_pos), .active(active), .locked(locked),
        .frame_start(frame_start), .timing_err(timing_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (h=%0d v=%0d t=%0t)", tag, got, exp, t2_h, t2_v, $time);
        end
    endtask

    task automatic clear_tags();
        t1_h = -1; t1_v = -1; t1_lk = 1'b0; t1_er = 1'b0;
        t2_h = -1; t2_v = -1; t2_lk = 1'b0; t2_er = 1'b0;
    endtask

    // Drive one sample; outputs seen now belong to the sample two clocks back
    task automatic step(input logic hs, input logic vs, input logic lk, input logic er,
                        input int h, input int v);
        logic ea;
        int   ex, ey;
        hsync_in = hs;
        vsync_in = vs;
        @(posedge clk);
        #1;
        ea = t2_lk && t2_h >= HS + HB && t2_h <= HS + HB + HV - 1 &&
             t2_v >= VS + VB && t2_v <= VS + VB + VV - 1;
        ex = ea ? t2_h - (HS + HB) : 0;
        ey = ea ? t2_v - (VS + VB) : 0;
        check("locked", locked, t2_lk);
        check("timing_err", timing_err, t2_er);
        check("active", active, ea);
        check("x_pos", x_pos, ex);
        check("y_pos", y_pos, ey);
        check("frame_start", frame_start, t2_lk && t2_h == 0 && t2_v == 0);
        t2_h = t1_h; t2_v = t1_v; t2_lk = t1_lk; t2_er = t1_er;
        t1_h = h;    t1_v = v;    t1_lk = lk;    t1_er = er;
    endtask

    // eh: sample index where the error pulses; lock is expected low from there on
    task automatic line(input int v, input int len, input int sw, input logic lk,
                        input int eh, input logic vlow);
        for (int h = 0; h < len; h++) begin
            logic l;
            l = (eh >= 0 && h >= eh) ? 1'b0 : lk;
            step((h < sw) ? 1'b0 : 1'b1, vlow ? 1'b0 : 1'b1, l, h == eh, h, v);
        end
    endtask

    // kind 1: one line a clock short; kind 2: narrow hsync; kind 3: hsync held high
    task automatic frame(input int nl, input logic lk, input int bad_line, input int kind,
                         input logic err0);
        logic lkc;
        lkc = lk;
        for (int v = 0; v < nl; v++) begin
            int len, sw, eh;
            len = HT; sw = HS; eh = -1;
            if (v == 0 && err0) eh = 0;
            if (kind == 1 && v == bad_line) len = HT - 1;
            if (kind == 1 && v == bad_line + 1) eh = 0;
            if (kind == 2 && v == bad_line) begin sw = HS - 1; eh = HS - 1; end
            if (kind == 3 && v == bad_line) begin len = 20; sw = 0; eh = 0; end
            line(v, len, sw, lkc, eh, v < VS);
            if (eh >= 0) lkc = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_tags();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, -1, -1);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, -1, -1);
    endtask

    initial begin
        do_reset();
        check("reset_locked", locked, 0);
        check("reset_x_pos", x_pos, 0);

        // Clean stream: CHECK at first vsync fall, lock at the third
        frame(VT, 1'b0, -1, 0, 1'b0);
        frame(VT, 1'b0, -1, 0, 1'b0);
        frame(VT, 1'b1, -1, 0, 1'b0);

        // One short line while locked, then relock
        frame(VT, 1'b1, 6, 1, 1'b0);
        frame(VT, 1'b0, -1, 0, 1'b0);
        frame(VT, 1'b0, -1, 0, 1'b0);
        frame(VT, 1'b1, -1, 0, 1'b0);

        // hsync stuck high while locked; later bad lines must stay silent in SEARCH
        frame(VT, 1'b1, 5, 3, 1'b0);
        frame(VT, 1'b0, -1, 0, 1'b0);
        frame(VT, 1'b0, -1, 0, 1'b0);
        frame(VT, 1'b1, -1, 0, 1'b0);

        // hsync pulse one clock narrow while locked
        frame(VT, 1'b1, 4, 2, 1'b0);
        frame(VT, 1'b0, -1, 0, 1'b0);
        frame(VT, 1'b0, -1, 0, 1'b0);
        frame(VT, 1'b1, -1, 0, 1'b0);

        // Reset mid-frame while locked
        for (int v = 0; v < 7; v++) line(v, HT, HS, 1'b1, -1, v < VS);
        for (int h = 0; h < 5; h++) step((h < HS) ? 1'b0 : 1'b1, 1'b1, 1'b1, 1'b0, h, 7);
        rst = 1'b1;
        #1;
        check("rst_locked", locked, 0);
        check("rst_active", active, 0);
        check("rst_x_pos", x_pos, 0);
        check("rst_y_pos", y_pos, 0);
        check("rst_frame_start", frame_start, 0);
        check("rst_timing_err", timing_err, 0);
        clear_tags();
        for (int h = 5; h < HT; h++) begin
            if (h == 9) rst = 1'b0;
            step(1'b1, 1'b1, 1'b0, 1'b0, h, 7);
        end
        for (int v = 8; v < VT; v++) line(v, HT, HS, 1'b0, -1, 1'b0);
        frame(VT, 1'b0, -1, 0, 1'b0);
        frame(VT, 1'b0, -1, 0, 1'b0);
        frame(VT, 1'b1, -1, 0, 1'b0);
        frame(VT, 1'b1, -1, 0, 1'b0);

        // Frame one line short during CHECK restarts the good-frame count
        do_reset();
        frame(VT, 1'b0, -1, 0, 1'b0);
        frame(VT - 1, 1'b0, -1, 0, 1'b0);
        frame(VT, 1'b0, -1, 0, 1'b1);
        frame(VT, 1'b0, -1, 0, 1'b0);
        frame(VT, 1'b1, -1, 0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1, 0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 2, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vga_sync_decoder.md
# vga_sync_decoder

Receive-side counterpart of the VGA timing generator. It samples an incoming hsync/vsync pair that runs on the same pixel clock and checks it against the configured 640x480 timing. Once the timing is confirmed, it recovers pixel coordinates and the active-video qualifier. It is used as an on-chip timing checker in the display path and as a loopback monitor in the bench. It locks only after a set number of conforming frames, and drops lock on the first violation.

## Interface
- H_VIS, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync low width (clocks)
- H_BACK, 48, horizontal back porch (clocks)
- V_VIS, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync low width (lines)
- V_BACK, 33, vertical back porch (lines)
- LOCK_FRAMES, 2, consecutive conforming frames required to lock (1..7)
- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-high reset
- hsync_in  in  1  horizontal sync, active low, synchronous to clk
- vsync_in  in  1  vertical sync, active low, synchronous to clk
- x_pos  out  10  recovered column; 0 when not active
- y_pos  out  10  recovered row; 0 when not active
- active  out  1  locked and inside the visible window
- locked  out  1  timing confirmed
- frame_start  out  1  one-cycle pulse at line 0, position 0 while locked
- timing_err  out  1  one-cycle pulse on any violation detected while in CHECK or LOCKED

## Operation
- Derived values: H_TOTAL = sum of the H_* parameters (800); V_TOTAL = sum of the V_* parameters (525).
- Position h:
  - h = 0 on the first low sample of hsync_in, i.e. the sample where the previous sample was high.
  - h increments by 1 per sample.
  - The counter is 11 bits and saturates at 2047.
- Line index v:
  - v increments at each hsync falling edge.
  - v = 0 on the first hsync falling edge at or after a vsync falling edge, including the same sample.
  - The counter is 11 bits and saturates.
- Visible window:
  - h in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_VIS-1] gives x = h-144.
  - v in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_VIS-1] gives y = v-35.
- Violations, each evaluated per line or frame:
  - hsync falling edge with h != H_TOTAL-1 before it (line length ≠ 800).
  - h reaches H_TOTAL with no falling edge (stuck or long line).
  - hsync rising edge with low width ≠ H_SYNC.
  - vsync falling edge with line count ≠ V_TOTAL.
  - vsync low for a number of hsync falling edges ≠ V_SYNC.
- FSM states: SEARCH, CHECK, LOCKED.
  - SEARCH: no checks, good-frame counter = 0; the first vsync falling edge moves to CHECK.
  - CHECK, violation: timing_err pulses, good counter is cleared, and the FSM stays in CHECK. A broken frame restarts the count at the next vsync falling edge.
  - CHECK, conforming frame: the good counter increments at the vsync falling edge that ends the frame. When it reaches LOCK_FRAMES, move to LOCKED.
  - LOCKED, violation: timing_err pulses and the FSM returns to SEARCH. locked, active and frame_start deassert in the same cycle that timing_err asserts.
- Simultaneous events: when a vsync falling edge coincides with an hsync falling edge, the frame-length check for the ending frame is evaluated before v is reset.

## Timing
- All outputs are registered.
- Fixed latency of 2 clocks: outputs in cycle t describe the input sample taken at the clock edge of cycle t-2.
- timing_err appears with the same 2-clock latency relative to the offending sample.
- locked rises with the same latency as the vsync falling-edge sample that completes lock. The first line then produces frame_start, but only if the next line is at v = 0.
- Reset values: x_pos = 0, y_pos = 0, active = 0, locked = 0, frame_start = 0, timing_err = 0. The FSM resets to SEARCH, the counters to 0 and the edge-detect history to high.
- Asserting reset mid-frame clears everything immediately. After release, a full SEARCH → CHECK → LOCKED sequence is required.

## Test plan
- Conformant 640x480 stream from reset, LOCK_FRAMES = 2:
  - locked is 0 through the first two frames after the first vsync falling edge.
  - locked rises 2 clocks after the third vsync falling-edge sample.
  - At h = 144, v = 35: x_pos = 0, y_pos = 0, active = 1, 2 clocks later.
  - At h = 783, v = 514: x_pos = 639, y_pos = 479.
- Locked stream, then one line of 799 clocks: timing_err pulses once, and locked and active drop in the same cycle. Relock occurs after 2 more good frames.
- Locked stream, hsync_in held high: timing_err at h = 800 (2-clock latency), and the FSM returns to SEARCH.
- CHECK phase, frame with 524 lines: no lock at that vsync edge. The good counter restarts, and locked rises only after 2 subsequent 525-line frames.
- Locked stream with one hsync pulse 95 clocks wide: timing_err on the hsync rising edge, and lock is lost.
- rst pulsed at v = 200 while locked: all outputs are 0 during reset. locked returns only after the full relock sequence. frame_start pulses once per frame thereafter, at v = 0, h = 0.
